// File: rtl/cpu_pkg.sv
// Shared decode-stage types: opcode map, micro-op structs and the combinational
// instruction decoder plus the hazard predicate used by cpu_decode.
package cpu_pkg;

    typedef enum logic [3:0] {
        NOP     = 4'h0,
        ADD     = 4'h1,
        SUB     = 4'h2,
        AND     = 4'h3,
        OR      = 4'h4,
        XOR     = 4'h5,
        ADDI    = 4'h6,
        LDI     = 4'h7,
        LD      = 4'h8,
        ST      = 4'h9,
        JMP     = 4'hA,
        ILLEGAL = 4'hB
    } op_t;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_ADD  = 4'h1;
    localparam logic [3:0] OPC_SUB  = 4'h2;
    localparam logic [3:0] OPC_AND  = 4'h3;
    localparam logic [3:0] OPC_OR   = 4'h4;
    localparam logic [3:0] OPC_XOR  = 4'h5;
    localparam logic [3:0] OPC_ADDI = 4'h6;
    localparam logic [3:0] OPC_LDI  = 4'h7;
    localparam logic [3:0] OPC_LD   = 4'h8;
    localparam logic [3:0] OPC_ST   = 4'h9;
    localparam logic [3:0] OPC_JMP  = 4'hA;

    // rd_rd / rd_rs: the op reads the register named in that field.
    typedef struct packed {
        op_t         op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] imm;
        logic        we;
        logic        rd_rd;
        logic        rd_rs;
    } uop_t;

    typedef struct packed {
        op_t         op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] imm;
        logic        we;
    } ex_t;

    localparam ex_t EX_RESET = '{op: NOP, rd: 4'h0, rs: 4'h0, imm: 16'h0, we: 1'b0};

    function automatic uop_t decode(input logic [15:0] ins, input logic [15:0] ext);
        uop_t        u;
        logic [15:0] sext;
        sext    = {{12{ins[IMM_HI]}}, ins[IMM_HI:IMM_LO]};
        u.op    = ILLEGAL;
        u.rd    = ins[RD_HI:RD_LO];
        u.rs    = ins[RS_HI:RS_LO];
        u.imm   = 16'h0;
        u.we    = 1'b0;
        u.rd_rd = 1'b0;
        u.rd_rs = 1'b0;
        case (ins[OPC_HI:OPC_LO])
            OPC_NOP: u.op = NOP;
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR: begin
                u.op    = op_t'(ins[OPC_HI:OPC_LO]);
                u.we    = 1'b1;
                u.rd_rd = 1'b1;
                u.rd_rs = 1'b1;
            end
            OPC_ADDI: begin
                u.op    = ADDI;
                u.we    = 1'b1;
                u.rd_rd = 1'b1;
                u.imm   = sext;
            end
            OPC_LDI: begin
                u.op  = LDI;
                u.we  = 1'b1;
                u.imm = ext;
            end
            OPC_LD: begin
                u.op    = LD;
                u.we    = 1'b1;
                u.rd_rs = 1'b1;
                u.imm   = sext;
            end
            OPC_ST: begin
                u.op    = ST;
                u.rd_rd = 1'b1;
                u.rd_rs = 1'b1;
                u.imm   = sext;
            end
            OPC_JMP: begin
                u.op  = JMP;
                u.imm = ext;
            end
            default: u.op = ILLEGAL;
        endcase
        if (u.rd == 4'd0) u.we = 1'b0;
        return u;
    endfunction

    function automatic logic stalls(input uop_t u, input logic [15:0] busy);
        return (u.rd_rd && busy[u.rd]) || (u.rd_rs && busy[u.rs]) || (u.we && busy[u.rd]);
    endfunction

    function automatic ex_t to_ex(input uop_t u);
        ex_t e;
        e.op  = u.op;
        e.rd  = u.rd;
        e.rs  = u.rs;
        e.imm = u.imm;
        e.we  = u.we;
        return e;
    endfunction

endpackage

// File: rtl/cpu_decode_fifo.sv
// Synchronous FIFO with occupancy count and flush. A push that finds no room is
// refused and reported on drop_o; a same-cycle pop makes room even when full.
module cpu_decode_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full, do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full || do_pop);
    assign drop_o  = push_i && !flush_i && !do_push;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; validity is carried by count/pointers alone.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cpu_decode.sv
// Decode stage: buffers fetch beats, decodes the head, holds it while a register
// hazard is pending on the busy scoreboard, and issues to execute over valid/ready.
module cpu_decode
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int FULL_MARGIN = 1
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [15:0] ins,
    input  logic [15:0] ext,
    input  logic        ins_en,
    output logic        dec_full,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [3:0]  ex_op,
    output logic [3:0]  ex_rd,
    output logic [3:0]  ex_rs,
    output logic [15:0] ex_imm,
    output logic        ex_we,
    input  logic        wb_en,
    input  logic [3:0]  wb_rd,
    output logic        ovf
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   head;
    logic [CW-1:0] count;
    logic          empty, drop, fire, load;
    uop_t          head_uop;
    ex_t           out_q, out_d;
    logic          valid_q, valid_d;
    logic [15:0]   sb_q, sb_d, busy;
    logic          ovf_q;

    cpu_decode_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .clk_i  (cpu_clk),
        .rst_i  (cpu_rst),
        .flush_i(flush),
        .push_i (ins_en),
        .pop_i  (load),
        .wdata_i({ins, ext}),
        .rdata_o(head),
        .count_o(count),
        .empty_o(empty),
        .drop_o (drop)
    );

    assign head_uop = decode(head[31:16], head[15:0]);
    assign fire     = valid_q && ex_ready;
    // The op leaving this cycle is not yet in sb_q but must already block its readers.
    assign busy     = sb_q | ((fire && out_q.we) ? (16'h1 << out_q.rd) : 16'h0);
    assign load     = (!valid_q || fire) && !empty && !flush && !stalls(head_uop, busy);

    always_comb begin
        // NOTE: every next-state variable gets a default first, so no latch is inferred.
        out_d   = out_q;
        valid_d = valid_q;
        sb_d    = sb_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            out_d   = to_ex(head_uop);
            valid_d = 1'b1;
        end else if (fire) begin
            valid_d = 1'b0;
        end
        if (wb_en)             sb_d[wb_rd]    = 1'b0;
        if (fire && out_q.we)  sb_d[out_q.rd] = 1'b1;
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            out_q   <= EX_RESET;
            valid_q <= 1'b0;
            sb_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            sb_q    <= sb_d;
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign dec_full = (CW'(FIFO_DEPTH) - count) <= CW'(FULL_MARGIN);
    assign ex_valid = valid_q;
    assign ex_op    = out_q.op;
    assign ex_rd    = out_q.rd;
    assign ex_rs    = out_q.rs;
    assign ex_imm   = out_q.imm;
    assign ex_we    = out_q.we;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_cpu_decode.sv
// Self-checking bench for cpu_decode: directed scenarios plus a randomized run
// compared every cycle against a queue-based reference model of the stage.
module tb_cpu_decode;

    localparam int DEPTH  = 4;
    localparam int MARGIN = 1;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [15:0] ins = '0, ext = '0;
    logic        ins_en = 1'b0, flush = 1'b0, ex_ready = 1'b0, wb_en = 1'b0;
    logic [3:0]  wb_rd = '0;
    logic        dec_full, ex_valid, ex_we, ovf;
    logic [3:0]  ex_op, ex_rd, ex_rs;
    logic [15:0] ex_imm;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic        m_valid;
    logic [3:0]  m_op, m_rd, m_rs;
    logic [15:0] m_imm;
    logic        m_we;
    logic [15:0] m_sb;
    logic        m_ovf;

    cpu_decode #(.FIFO_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .ins     (ins),
        .ext     (ext),
        .ins_en  (ins_en),
        .dec_full(dec_full),
        .flush   (flush),
        .ex_valid(ex_valid),
        .ex_ready(ex_ready),
        .ex_op   (ex_op),
        .ex_rd   (ex_rd),
        .ex_rs   (ex_rs),
        .ex_imm  (ex_imm),
        .ex_we   (ex_we),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .ovf     (ovf)
    );

    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Decoding straight from the instruction table; rmask = registers whose busy bit stalls the op.
    task automatic ref_decode(input logic [15:0] i, input logic [15:0] e,
                              output logic [3:0] op, output logic [3:0] rd, output logic [3:0] rs,
                              output logic [15:0] imm, output logic we, output logic [15:0] rmask);
        int   opc;
        logic r_rd, r_rs, wr;
        opc   = int'(i[15:12]);
        rd    = i[11:8];
        rs    = i[7:4];
        op    = (opc <= 10) ? i[15:12] : 4'd11;
        r_rd  = (opc >= 1 && opc <= 6) || opc == 9;
        r_rs  = (opc >= 1 && opc <= 5) || opc == 8 || opc == 9;
        wr    = (opc >= 1 && opc <= 8);
        we    = wr && (rd != 4'd0);
        if (opc == 6 || opc == 8 || opc == 9) imm = {{12{i[3]}}, i[3:0]};
        else if (opc == 7 || opc == 10)       imm = e;
        else                                  imm = 16'h0;
        rmask = 16'h0;
        if (r_rd) rmask[rd] = 1'b1;
        if (r_rs) rmask[rs] = 1'b1;
        if (we)   rmask[rd] = 1'b1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_valid = 1'b0;
        m_op = 4'h0; m_rd = 4'h0; m_rs = 4'h0; m_imm = 16'h0; m_we = 1'b0;
        m_sb  = 16'h0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step();
        logic        fire, pop, push, we;
        logic [15:0] busy, rmask, imm;
        logic [3:0]  op, rd, rs;
        fire = m_valid && ex_ready;
        busy = m_sb | ((fire && m_we) ? (16'h1 << m_rd) : 16'h0);
        pop  = 1'b0;
        op = 4'h0; rd = 4'h0; rs = 4'h0; imm = 16'h0; we = 1'b0; rmask = 16'h0;
        if (m_q.size() > 0) begin
            ref_decode(m_q[0][31:16], m_q[0][15:0], op, rd, rs, imm, we, rmask);
            pop = (!m_valid || fire) && !flush && ((rmask & busy) == 16'h0);
        end
        push = ins_en && !flush && (m_q.size() < DEPTH || pop);
        if (ins_en && !flush && !push) m_ovf = 1'b1;
        if (wb_en)          m_sb[wb_rd] = 1'b0;
        if (fire && m_we)   m_sb[m_rd]  = 1'b1;
        if (flush) begin
            m_q.delete();
            m_valid = 1'b0;
        end else begin
            if (pop) begin
                void'(m_q.pop_front());
                m_valid = 1'b1;
                m_op = op; m_rd = rd; m_rs = rs; m_imm = imm; m_we = we;
            end else if (fire) begin
                m_valid = 1'b0;
            end
            if (push) m_q.push_back({ins, ext});
        end
    endtask

    // One clock: inputs held since the last falling edge are applied, outputs settle by the next falling edge.
    task automatic cycle();
        @(posedge cpu_clk);
        model_step();
        @(negedge cpu_clk);
        ins_en = 1'b0;
        flush  = 1'b0;
        wb_en  = 1'b0;
    endtask

    task automatic do_reset();
        cpu_rst = 1'b1;
        ins_en = 1'b0; flush = 1'b0; wb_en = 1'b0; ex_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge cpu_clk);
        cpu_rst = 1'b0;
    endtask

    task automatic push_beat(input logic [15:0] i, input logic [15:0] e);
        ins = i; ext = e; ins_en = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
        n_checks++;
        if (ex_op !== 4'h0) begin n_fail++; $display("FAIL reset_ex_op: got %h want 0", ex_op); end
        n_checks++;
        if ({ex_rd, ex_rs, ex_imm, ex_we} !== 25'h0) begin
            n_fail++; $display("FAIL reset_ex_fields: got %h want 0", {ex_rd, ex_rs, ex_imm, ex_we});
        end
        n_checks++;
        if ({dec_full, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_full_ovf: got %b want 00", {dec_full, ovf}); end
        n_checks++;
        if (dut.sb_q !== 16'h0) begin n_fail++; $display("FAIL reset_scoreboard: got %h want 0", dut.sb_q); end
    endtask

    task automatic test_ldi();
        ex_ready = 1'b1;
        push_beat(16'h7123, 16'hBEEF);
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL ldi_too_early: got %b want 0", ex_valid); end
        cycle();
        n_checks++;
        if ({ex_valid, ex_op, ex_rd, ex_imm, ex_we} !== {1'b1, 4'h7, 4'h1, 16'hBEEF, 1'b1}) begin
            n_fail++;
            $display("FAIL ldi_issue: got %h want %h", {ex_valid, ex_op, ex_rd, ex_imm, ex_we},
                     {1'b1, 4'h7, 4'h1, 16'hBEEF, 1'b1});
        end
        cycle();
        n_checks++;
        if (dut.sb_q !== 16'h0002) begin n_fail++; $display("FAIL ldi_scoreboard: got %h want 0002", dut.sb_q); end
        wb_en = 1'b1; wb_rd = 4'd1;
        cycle();
        n_checks++;
        if (dut.sb_q !== 16'h0000) begin n_fail++; $display("FAIL ldi_wb_clear: got %h want 0000", dut.sb_q); end
    endtask

    task automatic test_hazard();
        ex_ready = 1'b1;
        push_beat(16'h7123, 16'h0042);
        push_beat(16'h1120, 16'h0000);
        n_checks++;
        if ({ex_valid, ex_op} !== {1'b1, 4'h7}) begin
            n_fail++; $display("FAIL hazard_ldi_out: got %h want 17", {ex_valid, ex_op});
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL hazard_held_%0d: got %b want 0", k, ex_valid); end
        end
        wb_en = 1'b1; wb_rd = 4'd1;
        cycle();
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL hazard_no_bypass: got %b want 0", ex_valid); end
        cycle();
        n_checks++;
        if ({ex_valid, ex_op, ex_rd, ex_rs, ex_imm, ex_we} !== {1'b1, 4'h1, 4'h1, 4'h2, 16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL hazard_release: got %h want %h", {ex_valid, ex_op, ex_rd, ex_rs, ex_imm, ex_we},
                     {1'b1, 4'h1, 4'h1, 4'h2, 16'h0, 1'b1});
        end
        cycle();
        wb_en = 1'b1; wb_rd = 4'd1;
        cycle();
    endtask

    task automatic test_imm_illegal();
        ex_ready = 1'b1;
        push_beat(16'h6F0F, 16'h1234);
        push_beat(16'hC000, 16'h5555);
        n_checks++;
        if ({ex_valid, ex_op, ex_rd, ex_imm, ex_we} !== {1'b1, 4'h6, 4'hF, 16'hFFFF, 1'b1}) begin
            n_fail++;
            $display("FAIL addi_sext: got %h want %h", {ex_valid, ex_op, ex_rd, ex_imm, ex_we},
                     {1'b1, 4'h6, 4'hF, 16'hFFFF, 1'b1});
        end
        cycle();
        n_checks++;
        if ({ex_valid, ex_op, ex_imm, ex_we} !== {1'b1, 4'hB, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_op: got %h want %h", {ex_valid, ex_op, ex_imm, ex_we}, {1'b1, 4'hB, 16'h0, 1'b0});
        end
        cycle();
        wb_en = 1'b1; wb_rd = 4'd15;
        cycle();
    endtask

    task automatic test_r0();
        ex_ready = 1'b1;
        push_beat(16'h1050, 16'h0);
        push_beat(16'h1000, 16'h0);
        n_checks++;
        if ({ex_valid, ex_op, ex_rs, ex_we} !== {1'b1, 4'h1, 4'h5, 1'b0}) begin
            n_fail++; $display("FAIL r0_no_write: got %h want %h", {ex_valid, ex_op, ex_rs, ex_we}, {1'b1, 4'h1, 4'h5, 1'b0});
        end
        cycle();
        n_checks++;
        if ({ex_valid, ex_rs, ex_we} !== {1'b1, 4'h0, 1'b0}) begin
            n_fail++; $display("FAIL r0_not_stalled: got %h want %h", {ex_valid, ex_rs, ex_we}, {1'b1, 4'h0, 1'b0});
        end
        cycle();
        n_checks++;
        if (dut.sb_q !== 16'h0) begin n_fail++; $display("FAIL r0_scoreboard: got %h want 0", dut.sb_q); end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        push_beat(16'h7300, 16'h00AA);
        push_beat(16'h0000, 16'h0);
        push_beat(16'h0000, 16'h0);
        push_beat(16'h0000, 16'h0);
        n_checks++;
        if ({ex_valid, ex_op, ex_rd, dec_full} !== {1'b1, 4'h7, 4'h3, 1'b1}) begin
            n_fail++; $display("FAIL flush_setup: got %h want %h", {ex_valid, ex_op, ex_rd, dec_full}, {1'b1, 4'h7, 4'h3, 1'b1});
        end
        ex_ready = 1'b1; flush = 1'b1; ins = 16'h0000; ext = 16'h0; ins_en = 1'b1;
        cycle();
        n_checks++;
        if ({ex_valid, dec_full, ovf} !== 3'b000) begin
            n_fail++; $display("FAIL flush_clear: got %b want 000", {ex_valid, dec_full, ovf});
        end
        n_checks++;
        if (dut.sb_q !== 16'h0008) begin n_fail++; $display("FAIL flush_fire_counts: got %h want 0008", dut.sb_q); end
        cycle();
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_fifo_empty: got %b want 0", ex_valid); end
        wb_en = 1'b1; wb_rd = 4'd3;
        cycle();
    endtask

    task automatic test_backpressure();
        logic [5:0] df_exp;
        logic [5:0] ovf_exp;
        df_exp  = 6'b111000;
        ovf_exp = 6'b100000;
        ex_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push_beat(16'((k + 1) * 16'h0110), 16'h0);
            n_checks++;
            if ({dec_full, ovf} !== {df_exp[k], ovf_exp[k]}) begin
                n_fail++; $display("FAIL bp_full_ovf_%0d: got %b want %b", k, {dec_full, ovf}, {df_exp[k], ovf_exp[k]});
            end
            if (k > 0) begin
                n_checks++;
                if ({ex_valid, ex_op, ex_rd, ex_rs, ex_we} !== {1'b1, 4'h0, 4'h1, 4'h1, 1'b0}) begin
                    n_fail++; $display("FAIL bp_stable_%0d: got %h want %h", k, {ex_valid, ex_op, ex_rd, ex_rs, ex_we},
                                       {1'b1, 4'h0, 4'h1, 4'h1, 1'b0});
                end
            end
        end
        ex_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cycle();
            n_checks++;
            if (j < 4) begin
                if ({ex_valid, ex_rd} !== {1'b1, 4'(j + 2)}) begin
                    n_fail++; $display("FAIL bp_drain_%0d: got %h want %h", j, {ex_valid, ex_rd}, {1'b1, 4'(j + 2)});
                end
            end else if (ex_valid !== 1'b0) begin
                n_fail++; $display("FAIL bp_drain_end: got %b want 0", ex_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        ex_ready = 1'b0;
        push_beat(16'h7500, 16'h1111);
        cycle();
        n_checks++;
        if ({ex_valid, ovf} !== 2'b11) begin n_fail++; $display("FAIL arst_precond: got %b want 11", {ex_valid, ovf}); end
        #2 cpu_rst = 1'b1;
        #1;
        n_checks++;
        if ({ex_valid, ovf, dec_full, ex_op} !== 7'h0 || dut.sb_q !== 16'h0) begin
            n_fail++; $display("FAIL arst_immediate: got %h/%h want 0/0", {ex_valid, ovf, dec_full, ex_op}, dut.sb_q);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [47:0] obs, exp;
        logic        exp_df;
        int          cands[$];
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ins_en   = ($urandom_range(0, 99) < 55);
            ins      = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
            ext      = 16'($urandom);
            ex_ready = ($urandom_range(0, 99) < 65);
            flush    = ($urandom_range(0, 99) < 3);
            cands.delete();
            for (int r = 0; r < 16; r++) if (m_sb[r]) cands.push_back(r);
            if (cands.size() > 0 && $urandom_range(0, 99) < 45) begin
                wb_en = 1'b1;
                wb_rd = 4'(cands[$urandom_range(0, cands.size() - 1)]);
            end else begin
                wb_en = ($urandom_range(0, 99) < 5);
                wb_rd = 4'($urandom_range(0, 15));
            end
            cycle();
            exp_df = ((DEPTH - m_q.size()) <= MARGIN);
            exp = {m_valid, m_valid ? {m_op, m_rd, m_rs, m_imm, m_we} : 29'h0, exp_df, m_ovf, m_sb};
            obs = {ex_valid, ex_valid ? {ex_op, ex_rd, ex_rs, ex_imm, ex_we} : 29'h0, dec_full, ovf, dut.sb_q};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL random_cycle_%0d: got %h want %h", n, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_hazard();
        test_imm_illegal();
        test_r0();
        test_flush();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
